arinc429_tx: RTL and testbench

ARINC 429 transmitter. It is the transmit-side counterpart of the existing ARINC 429 receive path. The block buffers 32-bit words in a small FIFO and serialises each word onto a bipolar RZ line pair (line_A / line_B), using the same line convention the receiver decodes. It sits on the system clock domain (typically clock = 400 kHz) and drives the line-driver pins or a loopback to a receiver instance.

---
 rtl/arinc429_tx.sv | 156 +++++++++++++++
 tb/tb_arinc429_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arinc429_tx.sv
// ARINC 429 transmitter: FIFO-buffered 32-bit words serialised MSB first as bipolar RZ on line_A/line_B.
// Build option ARINC429_TX_PARITY_EN: bit 0 of each word is replaced by odd parity over bits 31:1.
//
// state    | meaning
// S_IDLE   | waiting for a word in the FIFO
// S_LOAD   | pop FIFO head into the shift register, drive first bit
// S_BIT_HI | high half of the current bit on line_A or line_B
// S_BIT_LO | null half of the current bit, both lines low
// S_GAP    | inter-word null before the next word
module arinc429_tx #(
    parameter int HALF_BIT = 2,
    parameter int GAP_BITS = 4,
    parameter int FIFO_AW  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        busy,
    output logic        tx_done,
    output logic        line_A,
    output logic        line_B
);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int GAP_CYC = GAP_BITS * 2 * HALF_BIT;
    localparam int PH_MAX  = (GAP_CYC > HALF_BIT) ? GAP_CYC : HALF_BIT;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam logic [FIFO_AW:0] C_DEPTH = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_HI, S_BIT_LO, S_GAP} state_t;

    state_t             r_state;
    logic [31:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic [31:0]        r_shift;
    logic [5:0]         r_bit_cnt;
    logic [PH_W-1:0]    r_phase;
    logic               r_tx_done;
    logic               r_line_a;
    logic               r_line_b;

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;
    logic [31:0] w_load;
    logic [31:0] w_shift_next;
    logic [5:0]  w_bit_next;

    assign full         = (r_count == C_DEPTH);
    assign empty        = (r_count == '0);
    assign w_push       = wr_en & ~full;
    assign w_pop        = (r_state == S_LOAD);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_shift_next = r_shift << 1;
    assign w_bit_next   = r_bit_cnt + 6'd1;

    always_comb begin
        w_load = w_head;
`ifdef ARINC429_TX_PARITY_EN
        w_load[0] = ~^w_head[31:1];
`endif
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (wr_en && full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= '0;
            r_tx_done <= 1'b0;
            r_line_a  <= 1'b0;
            r_line_b  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift   <= w_load;
                    r_bit_cnt <= '0;
                    r_phase   <= PH_W'(HALF_BIT - 1);
                    r_line_a  <= w_load[31];
                    r_line_b  <= ~w_load[31];
                    r_state   <= S_BIT_HI;
                end
                S_BIT_HI: begin
                    if (r_phase == '0) begin
                        r_line_a <= 1'b0;
                        r_line_b <= 1'b0;
                        r_phase  <= PH_W'(HALF_BIT - 1);
                        r_state  <= S_BIT_LO;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_BIT_LO: begin
                    if (r_phase == '0) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= w_bit_next;
                        if (w_bit_next == 6'd32) begin
                            r_tx_done <= 1'b1;
                            r_phase   <= PH_W'(GAP_CYC - 1);
                            r_state   <= S_GAP;
                        end else begin
                            r_line_a <= w_shift_next[31];
                            r_line_b <= ~w_shift_next[31];
                            r_phase  <= PH_W'(HALF_BIT - 1);
                            r_state  <= S_BIT_HI;
                        end
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_phase == '0) r_state <= empty ? S_IDLE : S_LOAD;
                    else               r_phase <= r_phase - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);
    assign tx_done  = r_tx_done;
    assign line_A   = r_line_a;
    assign line_B   = r_line_b;

endmodule

// File: tb/tb_arinc429_tx.sv
// Testbench for arinc429_tx: a line monitor decodes RZ words into rx_q, writes push expected words into exp_q.
module tb_arinc429_tx;
    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_en   = 1'b0;
    logic        full, empty, overflow, busy, tx_done, line_A, line_B;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];
    int          gap_q[$];
    int          done_cnt  = 0;
    bit          both_seen = 1'b0;

    logic [31:0] mon_word = '0;
    int          mon_bits = 0;
    int          null_run = 0;
    bit          prev_hi  = 1'b0;
    bit          seen_hi  = 1'b0;

    arinc429_tx dut (
        .clock    (clock),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .tx_done  (tx_done),
        .line_A   (line_A),
        .line_B   (line_B)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_word(input logic [31:0] d);
        logic [31:0] r;
        int ones;
        r = d;
`ifdef ARINC429_TX_PARITY_EN
        ones = 0;
        for (int i = 1; i < 32; i++) ones += int'(d[i]);
        r[0] = ((ones % 2) == 0);
`else
        ones = 0;
`endif
        return r;
    endfunction

    // Receiver-style decoder: a high half starting after null is one bit, A=1 / B=0.
    always @(negedge clock) begin
        if (!reset) begin
            mon_bits = 0;
            null_run = 0;
            prev_hi  = 1'b0;
            seen_hi  = 1'b0;
        end else begin
            if (line_A && line_B) both_seen = 1'b1;
            if (tx_done) done_cnt++;
            if ((line_A || line_B) && !prev_hi) begin
                if (seen_hi && null_run < 50) gap_q.push_back(null_run);
                mon_word = {mon_word[30:0], line_A};
                mon_bits++;
                if (mon_bits == 32) begin
                    rx_q.push_back(mon_word);
                    mon_bits = 0;
                end
                null_run = 0;
                seen_hi  = 1'b1;
            end else if (!(line_A || line_B)) begin
                null_run++;
                if (null_run >= 8) mon_bits = 0;
            end
            prev_hi = line_A || line_B;
        end
    end

    task automatic push_write(input logic [31:0] d, input bit accept);
        @(posedge clock); #1;
        wr_data = d;
        wr_en   = 1'b1;
        if (accept) exp_q.push_back(exp_word(d));
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || !empty) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (busy || !empty) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%0b empty=%0b, required busy=0 empty=1", busy, empty);
        end
        repeat (60) @(negedge clock);
    endtask

    task automatic wait_rx(input int n, input string name);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (rx_q.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL %s_rx_timeout: got %0d words, required %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp += 7;
        if (line_A   !== 1'b0) begin n_err++; $display("FAIL rst_line_A: got %b, required 0", line_A); end
        if (line_B   !== 1'b0) begin n_err++; $display("FAIL rst_line_B: got %b, required 0", line_B); end
        if (empty    !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b, required 1", empty); end
        if (full     !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b, required 0", full); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        if (busy     !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (tx_done  !== 1'b0) begin n_err++; $display("FAIL rst_tx_done: got %b, required 0", tx_done); end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (20) @(negedge clock);
        n_cmp += 2;
        if (busy !== 1'b0 || line_A !== 1'b0 || line_B !== 1'b0) begin
            n_err++; $display("FAIL post_rst_quiet: busy=%b A=%b B=%b, required all 0", busy, line_A, line_B);
        end
        if (rx_q.size() != 0) begin n_err++; $display("FAIL post_rst_rx: got %0d words, required 0", rx_q.size()); end
    endtask

    task automatic test_single();
        int busy_cnt = 0, a_rise = 0, b_rise = 0, first_a = -1, d0;
        logic pa = 1'b0, pb = 1'b0, a2 = 1'b0, a3 = 1'b0, a4 = 1'b1;
        logic [31:0] got, want;
        wait_idle();
        d0 = done_cnt;
        push_write(32'h8000_0001, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            busy_cnt += int'(busy);
            if (line_A && !pa) a_rise++;
            if (line_B && !pb) b_rise++;
            if (line_A && first_a < 0) first_a = i;
            if (i == 2) a2 = line_A;
            if (i == 3) a3 = line_A;
            if (i == 4) a4 = line_A;
            pa = line_A;
            pb = line_B;
        end
        n_cmp += 7;
        if (first_a != 2) begin n_err++; $display("FAIL single_latency: first A at sample %0d, required 2", first_a); end
        if ({a2, a3, a4} !== 3'b110) begin n_err++; $display("FAIL single_first_half: A=%b%b%b, required 110", a2, a3, a4); end
        if (a_rise != 2) begin n_err++; $display("FAIL single_a_pulses: got %0d, required 2", a_rise); end
        if (b_rise != 30) begin n_err++; $display("FAIL single_b_pulses: got %0d, required 30", b_rise); end
        if (busy_cnt != 145) begin n_err++; $display("FAIL single_busy_len: got %0d, required 145", busy_cnt); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL single_tx_done: got %0d pulses, required 1", done_cnt - d0); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b, required 1", empty); end
        wait_rx(1, "single");
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL single_extra_word: got %h, required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin n_err++; $display("FAIL single_word: got %h, required %h", got, want); end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing: %0d words not seen, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, want;
        int n_two = 0, n_big = 0, big = 0;
        wait_idle();
        gap_q.delete();
        @(posedge clock); #1;
        wr_data = 32'hAAAA_AAAA; wr_en = 1'b1; exp_q.push_back(exp_word(32'hAAAA_AAAA));
        @(posedge clock); #1;
        wr_data = 32'h5555_5555; exp_q.push_back(exp_word(32'h5555_5555));
        @(posedge clock); #1;
        wr_en = 1'b0;
        wait_rx(2, "b2b");
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL b2b_extra_word: got %h, required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin n_err++; $display("FAIL b2b_word: got %h, required %h", got, want); end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: %0d words not seen, required 0", exp_q.size()); exp_q.delete(); end
        foreach (gap_q[i]) begin
            if (gap_q[i] == 2) n_two++;
            else begin n_big++; big = gap_q[i]; end
        end
        n_cmp += 3;
        if (n_big != 1) begin n_err++; $display("FAIL b2b_gap_count: got %0d long gaps, required 1", n_big); end
        if (big != 19) begin n_err++; $display("FAIL b2b_gap_len: got %0d null cycles, required 19", big); end
        if (n_two != 62) begin n_err++; $display("FAIL b2b_bit_nulls: got %0d, required 62", n_two); end
    endtask

    task automatic test_parity();
        logic [31:0] got, want;
        wait_idle();
        push_write(32'h0000_0002, 1'b1);
        wait_rx(1, "par_a");
        wait_idle();
        push_write(32'h0000_0000, 1'b1);
        wait_rx(2, "par_b");
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL parity_extra_word: got %h, required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin n_err++; $display("FAIL parity_word: got %h, required %h", got, want); end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL parity_missing: %0d words not seen, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    // Primer word keeps the FSM away from LOAD so the burst cannot be drained mid-write.
    task automatic test_overflow();
        logic [31:0] burst [5] = '{32'h0102_0304, 32'hF0F0_F0F0, 32'h1357_9BDF, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        logic [31:0] got, want;
        wait_idle();
        push_write(32'hC3C3_0F0F, 1'b1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b, required 0", overflow); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            wr_data = burst[k];
            wr_en   = 1'b1;
            if (k < 4) exp_q.push_back(exp_word(burst[k]));
        end
        @(posedge clock); #1;
        wr_en = 1'b0;
        @(negedge clock);
        n_cmp += 2;
        if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b, required 1", full); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        wait_rx(5, "ovf");
        wait_idle();
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL ovf_extra_word: got %h, required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin n_err++; $display("FAIL ovf_word: got %h, required %h", got, want); end
            end
        end
        n_cmp += 2;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_missing: %0d words not seen, required 0", exp_q.size()); exp_q.delete(); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_reset_mid_word();
        int d0, act = 0;
        wait_idle();
        d0 = done_cnt;
        push_write(32'hFFFF_FFFF, 1'b0);
        repeat (38) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (line_A !== 1'b1) begin n_err++; $display("FAIL midrst_pre_A: got %b, required 1", line_A); end
        #1 reset = 1'b0;
        #1;
        n_cmp += 4;
        if (line_A !== 1'b0 || line_B !== 1'b0) begin
            n_err++; $display("FAIL midrst_lines: A=%b B=%b, required 0 0", line_A, line_B);
        end
        if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b, required 1", empty); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b, required 0", overflow); end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (line_A || line_B || busy) act++;
        end
        n_cmp += 3;
        if (act != 0) begin n_err++; $display("FAIL midrst_resume: got %0d active cycles, required 0", act); end
        if (done_cnt != d0) begin n_err++; $display("FAIL midrst_tx_done: got %0d pulses, required 0", done_cnt - d0); end
        if (rx_q.size() != 0) begin n_err++; $display("FAIL midrst_rx: got %0d words, required 0", rx_q.size()); rx_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_overflow();
        test_reset_mid_word();
        n_cmp++;
        if (both_seen) begin n_err++; $display("FAIL lines_exclusive: got both high, required never"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
